// File: rtl/toplevel_ver3.sv
// Multi-core matmul top level: control FSM, masked core enables, streamed operand input,
// captured result bank and a serialised valid/ready result drain. Includes the systolic core.

module core #(
   parameter int unsigned WIDTH           = 16,
   parameter int unsigned FRAC_WIDTH      = 8,
   parameter int unsigned BLOCK_SIZE      = 2,
   parameter int unsigned CHUNK_SIZE      = 4,
   parameter int unsigned INNER_DIMENSION = 64
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          reset_acc,
   input  logic                          en,
   input  logic [WIDTH*CHUNK_SIZE-1:0]   input_n,
   input  logic [WIDTH*CHUNK_SIZE-1:0]   input_w,
   output logic [WIDTH*CHUNK_SIZE-1:0]   out,
   output logic                          accumulator_done,
   output logic                          systolic_finish
);

   localparam int unsigned BUS_W  = WIDTH*CHUNK_SIZE;
   localparam int unsigned PROD_W = 2*WIDTH;
   localparam int unsigned BEATS  = INNER_DIMENSION/BLOCK_SIZE;
   localparam int unsigned CNT_W  = $clog2(BEATS+2);

   logic [BUS_W-1:0]         prod_c;
   logic [BUS_W-1:0]         prod_r;
   logic [BUS_W-1:0]         acc_r;
   logic [CNT_W-1:0]         en_cnt;
   logic signed [WIDTH-1:0]  a_w;
   logic signed [WIDTH-1:0]  b_w;
   logic signed [PROD_W-1:0] p_w;

   // One block-product per beat: C[i][j] += sum_k N[i][k]*W[k][j], each product truncated to Q format
   always_comb begin
      prod_c = '0;
      a_w    = '0;
      b_w    = '0;
      p_w    = '0;
      for (int i = 0; i < BLOCK_SIZE; i++) begin
         for (int j = 0; j < BLOCK_SIZE; j++) begin
            for (int k = 0; k < BLOCK_SIZE; k++) begin
               a_w = $signed(input_n[(i*BLOCK_SIZE+k)*WIDTH +: WIDTH]);
               b_w = $signed(input_w[(k*BLOCK_SIZE+j)*WIDTH +: WIDTH]);
               p_w = PROD_W'(a_w) * PROD_W'(b_w);
               prod_c[(i*BLOCK_SIZE+j)*WIDTH +: WIDTH] =
                  prod_c[(i*BLOCK_SIZE+j)*WIDTH +: WIDTH] + WIDTH'(p_w >>> FRAC_WIDTH);
            end
         end
      end
   end

   // Product stage then accumulate stage; one extra enabled beat flushes the last product
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_r <= '0;
         acc_r  <= '0;
         en_cnt <= '0;
      end else if (reset_acc) begin
         prod_r <= '0;
         acc_r  <= '0;
         en_cnt <= '0;
      end else if (en) begin
         prod_r <= prod_c;
         for (int w = 0; w < CHUNK_SIZE; w++) begin
            acc_r[w*WIDTH +: WIDTH] <= acc_r[w*WIDTH +: WIDTH] + prod_r[w*WIDTH +: WIDTH];
         end
         if (en_cnt != CNT_W'(BEATS+1)) begin
            en_cnt <= en_cnt + CNT_W'(1);
         end
      end
   end

   assign out              = acc_r;
   assign accumulator_done = (en_cnt == CNT_W'(BEATS+1));
   assign systolic_finish  = (en_cnt >= CNT_W'(BEATS));

endmodule

module toplevel_ver3 #(
   parameter int unsigned WIDTH           = 16,
   parameter int unsigned FRAC_WIDTH      = 8,
   parameter int unsigned BLOCK_SIZE      = 2,
   parameter int unsigned CHUNK_SIZE      = 4,
   parameter int unsigned INNER_DIMENSION = 64,
   parameter int unsigned NUM_CORES       = 2,
   parameter int unsigned BEATS_PER_TILE  = INNER_DIMENSION/BLOCK_SIZE,
   parameter int unsigned DONE_TIMEOUT    = 256,
   localparam int unsigned IDX_W          = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                start,
   input  logic [NUM_CORES-1:0]                core_mask,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [WIDTH*CHUNK_SIZE-1:0]         input_n,
   input  logic [WIDTH*CHUNK_SIZE*NUM_CORES-1:0] input_w,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [WIDTH*CHUNK_SIZE-1:0]         out_data,
   output logic [IDX_W-1:0]                    out_core_idx,
   output logic                                out_last,
   output logic                                busy,
   output logic                                done,
   output logic                                timeout_err
);

   localparam int unsigned BUS_W  = WIDTH*CHUNK_SIZE;
   localparam int unsigned BEAT_W = $clog2(BEATS_PER_TILE+1);
   localparam int unsigned WAIT_W = $clog2(DONE_TIMEOUT+1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CLEAR   = 3'd1,
      S_FEED    = 3'd2,
      S_WAIT    = 3'd3,
      S_CAPTURE = 3'd4,
      S_DRAIN   = 3'd5
   } state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [NUM_CORES-1:0]    mask_r;
   logic [BEAT_W-1:0]       beat_cnt;
   logic [WAIT_W-1:0]       wait_cnt;
   logic [BUS_W-1:0]        bank [NUM_CORES];
   logic [BUS_W-1:0]        core_out [NUM_CORES];
   logic [NUM_CORES-1:0]    core_en;
   logic [NUM_CORES-1:0]    acc_done;
   logic [NUM_CORES-1:0]    unused_finish;
   logic [BUS_W-1:0]        core_n;
   logic [BUS_W*NUM_CORES-1:0] core_w;
   logic                    clr_acc;
   logic                    flush;
   logic                    all_done;
   logic                    tmo_hit;
   logic [IDX_W-1:0]        lo_idx;
   logic [IDX_W-1:0]        hi_idx;
   logic [IDX_W-1:0]        nxt_idx;
   logic                    lo_found;
   logic                    nxt_found;

   assign all_done = &(acc_done | ~mask_r);
   assign tmo_hit  = !all_done && (wait_cnt == WAIT_W'(DONE_TIMEOUT-1));
   assign core_n   = flush ? '0 : input_n;
   assign core_w   = flush ? '0 : input_w;

   // Lowest, highest and next-above-current set bits of the job mask drive the drain order
   always_comb begin
      lo_idx    = '0;
      hi_idx    = '0;
      nxt_idx   = out_core_idx;
      lo_found  = 1'b0;
      nxt_found = 1'b0;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (mask_r[i] && !lo_found) begin
            lo_idx   = IDX_W'(i);
            lo_found = 1'b1;
         end
         if (mask_r[i]) begin
            hi_idx = IDX_W'(i);
         end
         if (mask_r[i] && !nxt_found && (IDX_W'(i) > out_core_idx)) begin
            nxt_idx   = IDX_W'(i);
            nxt_found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      core_en   = '0;
      clr_acc   = 1'b0;
      flush     = 1'b0;
      case (state)
         S_IDLE: begin
            if (start && (|core_mask)) begin
               state_nxt = S_CLEAR;
            end
         end
         S_CLEAR: begin
            clr_acc   = 1'b1;
            state_nxt = S_FEED;
         end
         S_FEED: begin
            core_en = in_valid ? mask_r : '0;
            if (in_valid && (beat_cnt == BEAT_W'(BEATS_PER_TILE-1))) begin
               state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            flush   = 1'b1;
            core_en = mask_r;
            if (all_done || tmo_hit) begin
               state_nxt = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (out_ready && out_last) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Job registers, result bank and registered handshake/status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mask_r       <= '0;
         beat_cnt     <= '0;
         wait_cnt     <= '0;
         in_ready     <= 1'b0;
         out_valid    <= 1'b0;
         out_data     <= '0;
         out_core_idx <= '0;
         out_last     <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         timeout_err  <= 1'b0;
         for (int i = 0; i < NUM_CORES; i++) begin
            bank[i] <= '0;
         end
      end else begin
         done     <= 1'b0;
         busy     <= (state_nxt != S_IDLE);
         in_ready <= (state_nxt == S_FEED);
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (|core_mask) begin
                     mask_r      <= core_mask;
                     timeout_err <= 1'b0;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            S_CLEAR: begin
               beat_cnt <= '0;
               wait_cnt <= '0;
            end
            S_FEED: begin
               if (in_valid) begin
                  beat_cnt <= beat_cnt + BEAT_W'(1);
               end
            end
            S_WAIT: begin
               wait_cnt <= wait_cnt + WAIT_W'(1);
               if (tmo_hit) begin
                  timeout_err <= 1'b1;
               end
            end
            S_CAPTURE: begin
               for (int i = 0; i < NUM_CORES; i++) begin
                  if (mask_r[i]) begin
                     bank[i] <= core_out[i];
                  end
               end
               out_valid    <= 1'b1;
               out_data     <= core_out[lo_idx];
               out_core_idx <= lo_idx;
               out_last     <= (lo_idx == hi_idx);
            end
            S_DRAIN: begin
               if (out_ready) begin
                  if (out_last) begin
                     out_valid    <= 1'b0;
                     out_data     <= '0;
                     out_core_idx <= '0;
                     out_last     <= 1'b0;
                     done         <= 1'b1;
                  end else begin
                     out_data     <= bank[nxt_idx];
                     out_core_idx <= nxt_idx;
                     out_last     <= (nxt_idx == hi_idx);
                  end
               end
            end
            default: begin
               beat_cnt <= '0;
            end
         endcase
      end
   end

   for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
      core #(
         .WIDTH           (WIDTH),
         .FRAC_WIDTH      (FRAC_WIDTH),
         .BLOCK_SIZE      (BLOCK_SIZE),
         .CHUNK_SIZE      (CHUNK_SIZE),
         .INNER_DIMENSION (INNER_DIMENSION)
      ) u_core (
         .clk              (clk),
         .rst_n            (rst_n),
         .reset_acc        (clr_acc),
         .en               (core_en[g]),
         .input_n          (core_n),
         .input_w          (core_w[g*BUS_W +: BUS_W]),
         .out              (core_out[g]),
         .accumulator_done (acc_done[g]),
         .systolic_finish  (unused_finish[g])
      );
   end

endmodule

// File: tb/tb_toplevel_ver3.sv
// Self-checking bench for toplevel_ver3: table of job configurations checked against a
// matrix-product reference model, plus hand sequences for zero mask and mid-job reset.

module tb_toplevel_ver3;

   localparam int NC = 5;
   localparam int BW = 64;
   localparam int NB = 32;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [NC-1:0]    core_mask;
   logic             in_valid;
   logic             in_ready;
   logic [BW-1:0]    input_n;
   logic [BW*NC-1:0] input_w;
   logic             out_valid;
   logic             out_ready;
   logic [BW-1:0]    out_data;
   logic [2:0]       out_core_idx;
   logic             out_last;
   logic             busy;
   logic             done;
   logic             timeout_err;

   int n_pass = 0;
   int n_tot  = 0;

   logic [BW-1:0]    nb [NB];
   logic [BW*NC-1:0] wb [NB];

   typedef struct {
      logic [NC-1:0] mask;
      int            vmode;    // 0 always valid, 1 every other cycle, 2 random
      int            rmode;    // 0 always ready, 1 stall first beat 10 cycles, 2 random
      int            dmode;    // 0 all words 1.0, 1 random words
      bit            poke;     // assert start mid-FEED
      bit            tmo;      // hold core 1 done low
      int            exp_beats;
      bit            exp_tmo;
   } vec_t;

   vec_t tbl [8];

   toplevel_ver3 #(
      .NUM_CORES    (NC),
      .DONE_TIMEOUT (16)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .core_mask    (core_mask),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .input_n      (input_n),
      .input_w      (input_w),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_core_idx (out_core_idx),
      .out_last     (out_last),
      .busy         (busy),
      .done         (done),
      .timeout_err  (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: C = sum over beats of N(2x2) * W_c(2x2), each product >>8 and wrapped to 16 bits
   function automatic logic [63:0] model_core(input int c);
      shortint   acc [4];
      shortint   a;
      shortint   b;
      int        p;
      logic [63:0] r;
      for (int e = 0; e < 4; e++) acc[e] = 0;
      for (int bt = 0; bt < NB; bt++)
         for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
               for (int k = 0; k < 2; k++) begin
                  a = shortint'(nb[bt][(i*2+k)*16 +: 16]);
                  b = shortint'(wb[bt][c*64 + (k*2+j)*16 +: 16]);
                  p = int'(a) * int'(b);
                  acc[i*2+j] += shortint'(p >>> 8);
               end
      for (int e = 0; e < 4; e++) r[e*16 +: 16] = acc[e];
      return r;
   endfunction

   task automatic run_job(input vec_t v, input string nm);
      logic [63:0] expv [NC];
      int          order [$];
      int          cyc, accepts, ready_cnt, xfers, done_cnt, viol, unstable, stall;
      int          acc_cyc, tmo_cyc;
      bit          finished, poked, pre_ready, pre_ov, pre_last;
      logic [63:0] pre_data;
      logic [2:0]  pre_idx;
      cyc = 0; accepts = 0; ready_cnt = 0; xfers = 0; done_cnt = 0; viol = 0;
      unstable = 0; stall = 0; acc_cyc = -1; tmo_cyc = -1; finished = 0; poked = 0;

      for (int bt = 0; bt < NB; bt++) begin
         for (int w = 0; w < 4; w++) nb[bt][w*16 +: 16] = (v.dmode == 0) ? 16'h0100 : 16'($urandom);
         for (int w = 0; w < 4*NC; w++) wb[bt][w*16 +: 16] = (v.dmode == 0) ? 16'h0100 : 16'($urandom);
      end
      for (int c = 0; c < NC; c++) expv[c] = (v.dmode == 0) ? {4{16'h4000}} : model_core(c);
      for (int c = 0; c < NC; c++) if (v.mask[c]) order.push_back(c);

      if (v.tmo) force dut.acc_done = 5'b11101;
      start = 1'b1;
      core_mask = v.mask;
      step();
      start = 1'b0;
      core_mask = NC'($urandom);
      chk({nm, " busy_after_start"}, 64'(busy), 64'd1);
      chk({nm, " tmo_cleared_on_start"}, 64'(timeout_err), 64'd0);

      while (!finished && cyc < 1500) begin
         in_valid = (accepts < NB) && ((v.vmode == 0) ? 1'b1 :
                                       (v.vmode == 1) ? (cyc % 2 == 1) :
                                       ($urandom_range(0, 3) != 0));
         if (in_valid) begin
            input_n = nb[accepts];
            input_w = wb[accepts];
         end else begin
            input_n = {$urandom, $urandom};
            input_w = {10{$urandom}};
         end
         if (v.rmode == 1 && out_valid && stall < 10) begin
            out_ready = 1'b0;
            stall++;
         end else if (v.rmode == 2) out_ready = 1'($urandom_range(0, 1));
         else out_ready = 1'b1;
         if (v.poke && !poked && accepts == 5) begin
            start = 1'b1;
            core_mask = 5'b11111;
            poked = 1;
         end
         pre_ready = in_ready; pre_ov = out_valid; pre_data = out_data;
         pre_idx = out_core_idx; pre_last = out_last;
         if (in_ready) ready_cnt++;
         #3;
         if ((dut.core_en & ~v.mask) != '0) viol++;
         step();
         cyc++;
         start = 1'b0;
         if (done) done_cnt++;
         if (pre_ready && in_valid) begin
            accepts++;
            if (accepts == NB) acc_cyc = cyc;
         end
         if (timeout_err && tmo_cyc < 0) tmo_cyc = cyc;
         if (pre_ov && !out_ready &&
             (!out_valid || out_data !== pre_data || out_core_idx !== pre_idx || out_last !== pre_last))
            unstable++;
         if (pre_ov && out_ready) begin
            if (xfers < order.size()) begin
               chk({nm, " drain_idx"}, 64'(pre_idx), 64'(order[xfers]));
               chk({nm, " drain_data"}, pre_data, expv[order[xfers]]);
               chk({nm, " drain_last"}, 64'(pre_last), 64'(xfers == order.size() - 1));
            end else chk({nm, " extra_beat"}, 64'(xfers), 64'(order.size()));
            xfers++;
            if (pre_last) begin
               finished = 1;
               chk({nm, " done_after_last"}, 64'(done), 64'd1);
               chk({nm, " busy_low_with_done"}, 64'(busy), 64'd0);
            end
         end
      end

      chk({nm, " finished"}, 64'(finished), 64'd1);
      chk({nm, " beats"}, 64'(xfers), 64'(v.exp_beats));
      chk({nm, " accepts"}, 64'(accepts), 64'(NB));
      chk({nm, " done_count"}, 64'(done_cnt), 64'd1);
      chk({nm, " masked_en"}, 64'(viol), 64'd0);
      chk({nm, " stall_stable"}, 64'(unstable), 64'd0);
      chk({nm, " timeout_err"}, 64'(timeout_err), 64'(v.exp_tmo));
      if (v.vmode == 0) chk({nm, " ready_cycles"}, 64'(ready_cnt), 64'(NB));
      if (v.tmo) chk({nm, " timeout_latency"}, 64'(tmo_cyc - acc_cyc), 64'd16);
      if (v.rmode == 1) chk({nm, " stall_cycles"}, 64'(stall), 64'd10);
      step();
      chk({nm, " done_one_cycle"}, 64'(done), 64'd0);
      if (v.tmo) release dut.acc_done;
   endtask

   task automatic check_zero_outputs(input string nm);
      chk({nm, " busy"}, 64'(busy), 64'd0);
      chk({nm, " in_ready"}, 64'(in_ready), 64'd0);
      chk({nm, " out_valid"}, 64'(out_valid), 64'd0);
      chk({nm, " out_data"}, out_data, 64'd0);
      chk({nm, " out_core_idx"}, 64'(out_core_idx), 64'd0);
      chk({nm, " out_last"}, 64'(out_last), 64'd0);
      chk({nm, " done"}, 64'(done), 64'd0);
      chk({nm, " timeout_err"}, 64'(timeout_err), 64'd0);
   endtask

   initial begin
      int bad;
      rst_n = 1'b0; start = 1'b0; core_mask = '0; in_valid = 1'b0;
      input_n = '0; input_w = '0; out_ready = 1'b0;

      tbl[0] = '{5'b00011, 0, 0, 0, 1'b0, 1'b0, 2, 1'b0};
      tbl[1] = '{5'b10100, 0, 0, 1, 1'b0, 1'b0, 2, 1'b0};
      tbl[2] = '{5'b00011, 1, 0, 0, 1'b0, 1'b0, 2, 1'b0};
      tbl[3] = '{5'b00011, 0, 1, 1, 1'b0, 1'b0, 2, 1'b0};
      tbl[4] = '{5'b11111, 2, 2, 1, 1'b1, 1'b0, 5, 1'b0};
      tbl[5] = '{5'b00011, 0, 0, 0, 1'b0, 1'b1, 2, 1'b1};
      tbl[6] = '{5'b00001, 2, 2, 1, 1'b0, 1'b0, 1, 1'b0};
      tbl[7] = '{5'b10000, 0, 0, 1, 1'b0, 1'b0, 1, 1'b0};

      repeat (3) @(posedge clk);
      #1;
      check_zero_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      step();

      for (int t = 0; t < 8; t++) begin
         run_job(tbl[t], $sformatf("job%0d", t));
         repeat (2) step();
      end

      // Zero mask: done next cycle, never busy or ready
      start = 1'b1;
      core_mask = '0;
      step();
      start = 1'b0;
      chk("mask0 done", 64'(done), 64'd1);
      chk("mask0 busy", 64'(busy), 64'd0);
      chk("mask0 in_ready", 64'(in_ready), 64'd0);
      step();
      chk("mask0 done_clear", 64'(done), 64'd0);
      chk("mask0 busy_after", 64'(busy), 64'd0);

      // Reset in the middle of FEED
      start = 1'b1;
      core_mask = 5'b00011;
      step();
      start = 1'b0;
      in_valid = 1'b1;
      input_n = {4{16'h0100}};
      input_w = {20{16'h0100}};
      repeat (11) step();
      chk("midfeed in_ready_before", 64'(in_ready), 64'd1);
      rst_n = 1'b0;
      #1;
      check_zero_outputs("midreset");
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      repeat (6) begin
         step();
         if (done || busy || out_valid) bad++;
      end
      chk("midreset no_done", 64'(bad), 64'd0);

      run_job(tbl[0], "recover");

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/toplevel_ver3.md
Name: toplevel_ver3

Overview:
Parametrised successor to the multi-core matmul top level. Instantiates NUM_CORES systolic `core` instances for any count from 1 to 32, with no fixed case list. Adds a control FSM, a per-job core-enable mask, valid/ready input streaming, a captured result bank and a serialised valid/ready output drain. Sits between the tile-fetch logic and the result writer in top_v3.

Parameters:
WIDTH, 16, fixed-point word width
FRAC_WIDTH, 8, fractional bits (passed to cores)
BLOCK_SIZE, 2, systolic array dimension (passed to cores)
CHUNK_SIZE, 4, words per core bus
INNER_DIMENSION, 64, shared matrix dimension (passed to cores)
NUM_CORES, 2, core count, 1..32
BEATS_PER_TILE, INNER_DIMENSION/BLOCK_SIZE (32), accepted input beats per job
DONE_TIMEOUT, 256, max WAIT cycles before timeout_err

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  job request, sampled in IDLE only
core_mask  in  NUM_CORES  active cores for the job, latched on start
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid&in_ready
input_n  in  WIDTH*CHUNK_SIZE  shared operand, broadcast to all cores
input_w  in  WIDTH*CHUNK_SIZE*NUM_CORES  per-core operand; core i uses slice [(i+1)*W*C-1 -: W*C]
out_valid  out  1  result beat valid
out_ready  in  1  result beat consumed
out_data  out  WIDTH*CHUNK_SIZE  captured output of one core
out_core_idx  out  max(1,clog2(NUM_CORES))  index of the core whose result is on out_data
out_last  out  1  final beat of the job
busy  out  1  state != IDLE
done  out  1  one-cycle job-complete pulse
timeout_err  out  1  sticky; cleared on an accepted start

Behaviour:
- Reset: asynchronous. State goes to IDLE. All outputs, the result bank, the mask register and all counters are cleared to 0. rst_n also goes to every core.
- Reset mid-job: aborts the job immediately. No done pulse is produced.
- States: IDLE, CLEAR, FEED, WAIT, CAPTURE, DRAIN.
- IDLE:
  - start with |core_mask: latch core_mask into mask_r, clear timeout_err, go to CLEAR.
  - start with core_mask==0: done pulses in the next cycle, state stays IDLE, busy stays low.
  - start while busy is ignored.
- CLEAR (1 cycle): reset_acc=1 to all cores, core en=0, beat_cnt cleared. Next state FEED.
- FEED:
  - in_ready=1.
  - Core i en = in_valid & mask_r[i]. input_n and input_w pass combinationally to the cores (zero added latency).
  - in_valid low: all core en=0, so cores hold state; stalls are unlimited.
  - beat_cnt increments per accepted beat. The accept at beat_cnt==BEATS_PER_TILE-1 moves to WAIT.
  - in_ready=0 in every other state.
- WAIT:
  - Core i en = mask_r[i]; core inputs are forced to 0 (flush).
  - all_done = &(accumulator_done | ~mask_r). When all_done, go to CAPTURE.
  - wait_cnt reaches DONE_TIMEOUT: set timeout_err and go to CAPTURE anyway.
  - systolic_finish from the cores is unused.
- CAPTURE (1 cycle):
  - Core en=0.
  - bank[i] <= core i out for each set mask_r bit; bank entries of masked cores keep their old values.
  - idx <= lowest set bit of mask_r. Next state DRAIN.
- DRAIN:
  - out_valid=1, out_data=bank[idx], out_core_idx=idx.
  - out_last=1 when idx is the highest set bit of mask_r.
  - Outputs stay stable while out_valid & !out_ready.
  - On transfer, idx moves to the next set bit above idx; masked cores are skipped with no gap cycles.
  - Transfer with out_last: go to IDLE. done=1 for exactly the next cycle, in which busy is already 0.
- Masked cores: en is never asserted during the job. reset_acc still reaches them in CLEAR.
- Arithmetic: none in this block. Words are passed and stored unmodified, WIDTH-bit two's complement Q(WIDTH-FRAC_WIDTH).FRAC_WIDTH.

Test Plan:
1. NUM_CORES=2, mask=2'b11, in_valid held high, all input words 1.0 (0x0100) -> in_ready high exactly 32 cycles; drain emits idx 0 then idx 1; every element equals the golden model value (64.0 = 0x4000); out_last on idx 1; done pulses 1 cycle after the last transfer.
2. NUM_CORES=5, mask=5'b10100 -> only idx 2 and 4 are emitted, back-to-back; en of cores 0, 1 and 3 never asserts; out_last on idx 4.
3. Test 1 with in_valid toggling every other cycle -> 32 accepts over about 64 cycles; results bit-identical to test 1.
4. out_ready held low for 10 cycles on the first drain beat -> out_data and out_core_idx stable throughout; no beat is lost or duplicated.
5. start with mask=0 -> in_ready never rises, busy stays 0, done pulses 1 cycle later; start asserted during FEED -> ignored.
6. DONE_TIMEOUT=16 with core 1 accumulator_done forced low -> timeout_err rises 16 cycles into WAIT and the drain still completes. Separate run: rst_n pulsed low mid-FEED -> all outputs 0 immediately, no done pulse.
